input_conditioner: RTL and testbench

- Front-end stage feeding the display sequencer.
- Generates the periodic `Tick` the sequencer counts time with.
- Converts the raw, asynchronous, bouncing minute/hour set buttons into clean single-cycle `SyncMinIn`/`SyncHourIn` pulses, with auto-repeat while a button is held.
- All outputs are registered in the `Clock` domain and connect directly to the sequencer's like-named inputs.

---
 rtl/input_conditioner.sv | 117 +++++++++++
 tb/tb_input_conditioner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Front end for the display sequencer: tick prescaler plus
// synchronised, debounced, auto-repeating set buttons.
module input_conditioner #(
  parameter int TICK_DIV      = 32768,
  parameter int DB_DIV        = 256,
  parameter int DB_COUNT      = 4,
  parameter int REPEAT_DELAY  = 128,
  parameter int REPEAT_PERIOD = 32
) (
  input  logic Clock,
  input  logic nReset,
  input  logic MinIn,
  input  logic HourIn,
  output logic Tick,
  output logic SyncMinIn,
  output logic SyncHourIn
);

  localparam int TW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
  localparam int SW = ($clog2(DB_DIV) < 1) ? 1 : $clog2(DB_DIV);
  localparam int AW = $clog2(DB_COUNT + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(DB_DIV - 1);
  localparam logic [AW-1:0] AGREE_END = AW'(DB_COUNT);
  localparam logic [RW-1:0] REP_END   = RW'(REPEAT_DELAY);
  // Clamp keeps the reload legal when the period exceeds the delay
  localparam logic [RW-1:0] REP_LOAD  =
    (REPEAT_DELAY > REPEAT_PERIOD) ?
    RW'(REPEAT_DELAY - REPEAT_PERIOD) : '0;

  logic [TW-1:0] r_tick_cnt;
  logic          r_tick;
  logic [SW-1:0] r_stb_cnt;
  logic          r_stb;
  logic [1:0]    w_raw;
  logic [1:0]    w_pulse;

  assign w_raw = {HourIn, MinIn};

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
      r_stb_cnt  <= '0;
      r_stb      <= 1'b0;
    end else begin
      r_tick     <= (r_tick_cnt == TICK_LAST);
      r_tick_cnt <= (r_tick_cnt == TICK_LAST) ?
                    '0 : r_tick_cnt + TW'(1);
      r_stb      <= (r_stb_cnt == STB_LAST);
      r_stb_cnt  <= (r_stb_cnt == STB_LAST) ?
                    '0 : r_stb_cnt + SW'(1);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [AW-1:0] r_agree;
    logic [RW-1:0] r_rep;
    logic          r_pulse;
    logic [AW-1:0] w_agree_inc;
    logic [RW-1:0] w_rep_inc;
    logic          w_toggle;
    logic          w_rep_hit;

    always_comb begin
      w_agree_inc = r_agree + AW'(1);
      w_rep_inc   = r_rep + RW'(1);
      w_toggle    = r_stb && (r_sync2 != r_db) &&
                    (w_agree_inc == AGREE_END);
      // A release toggle wins over a repeat due on the same strobe
      w_rep_hit   = r_stb && r_db && !w_toggle &&
                    (w_rep_inc == REP_END);
    end

    always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_db    <= 1'b0;
        r_agree <= '0;
        r_rep   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
        r_pulse <= (w_toggle && !r_db) || w_rep_hit;
        if (r_stb) begin
          if (r_sync2 == r_db) begin
            r_agree <= '0;
          end else if (w_toggle) begin
            r_agree <= '0;
            r_db    <= ~r_db;
          end else begin
            r_agree <= w_agree_inc;
          end
          if (w_toggle) begin
            r_rep <= '0;
          end else if (r_db) begin
            r_rep <= w_rep_hit ? REP_LOAD : w_rep_inc;
          end
        end
      end
    end

    assign w_pulse[g] = r_pulse;
  end

  assign Tick       = r_tick;
  assign SyncMinIn  = w_pulse[0];
  assign SyncHourIn = w_pulse[1];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with small dividers
// so debounce and repeat timing fit in a few hundred cycles.
module tb_input_conditioner;

  logic Clock  = 1'b0;
  logic nReset = 1'b0;
  logic MinIn  = 1'b0;
  logic HourIn = 1'b0;
  logic Tick;
  logic SyncMinIn;
  logic SyncHourIn;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  input_conditioner #(
    .TICK_DIV(8),
    .DB_DIV(4),
    .DB_COUNT(3),
    .REPEAT_DELAY(6),
    .REPEAT_PERIOD(2)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .MinIn(MinIn),
    .HourIn(HourIn),
    .Tick(Tick),
    .SyncMinIn(SyncMinIn),
    .SyncHourIn(SyncHourIn)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic align4();
    while (cyc % 4 != 0) step();
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({Tick, SyncMinIn, SyncHourIn} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outs got=%b exp=000",
                 {Tick, SyncMinIn, SyncHourIn});
      end
    end
    nReset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_tick_idle();
    int nt = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (Tick === 1'b1) nt++;
      checks++;
      if (Tick !== (cyc % 8 == 0)) begin
        errors++;
        $display("FAIL tick cyc=%0d got=%b exp=%b",
                 cyc, Tick, (cyc % 8 == 0));
      end
      checks++;
      if ({SyncMinIn, SyncHourIn} !== 2'b00) begin
        errors++;
        $display("FAIL idle_pulse cyc=%0d got=%b exp=00",
                 cyc, {SyncMinIn, SyncHourIn});
      end
    end
    checks++;
    if (nt != 12) begin
      errors++;
      $display("FAIL tick_count got=%0d exp=12", nt);
    end
  endtask

  task automatic test_single_press();
    int np = 0;
    align4();
    MinIn = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (SyncMinIn === 1'b1) np++;
      checks++;
      if (SyncMinIn !== (i == 13)) begin
        errors++;
        $display("FAIL press_min off=%0d got=%b exp=%b",
                 i, SyncMinIn, (i == 13));
      end
      checks++;
      if (SyncHourIn !== 1'b0) begin
        errors++;
        $display("FAIL press_hour off=%0d got=%b exp=0",
                 i, SyncHourIn);
      end
      if (i == 24) MinIn = 1'b0;
    end
    checks++;
    if (np != 1) begin
      errors++;
      $display("FAIL press_count got=%0d exp=1", np);
    end
  endtask

  task automatic test_bounce();
    int lens[3] = '{1, 5, 9};
    int np = 0;
    foreach (lens[k]) begin
      align4();
      MinIn = 1'b1;
      for (int i = 1; i <= 24; i++) begin
        step();
        if (SyncMinIn === 1'b1) np++;
        checks++;
        if (SyncMinIn !== 1'b0) begin
          errors++;
          $display("FAIL bounce len=%0d off=%0d got=%b exp=0",
                   lens[k], i, SyncMinIn);
        end
        if (i == lens[k]) MinIn = 1'b0;
      end
    end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL bounce_count got=%0d exp=0", np);
    end
  endtask

  task automatic test_repeat();
    int np = 0;
    logic e;
    align4();
    HourIn = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      step();
      e = (i inside {13, 37, 45, 53, 61, 69});
      if (SyncHourIn === 1'b1) np++;
      checks++;
      if (SyncHourIn !== e) begin
        errors++;
        $display("FAIL repeat_hour off=%0d got=%b exp=%b",
                 i, SyncHourIn, e);
      end
      checks++;
      if (SyncMinIn !== 1'b0) begin
        errors++;
        $display("FAIL repeat_min off=%0d got=%b exp=0",
                 i, SyncMinIn);
      end
      if (i == 60) HourIn = 1'b0;
    end
    checks++;
    if (np != 6) begin
      errors++;
      $display("FAIL repeat_count got=%0d exp=6", np);
    end
  endtask

  task automatic test_simultaneous();
    align4();
    MinIn  = 1'b1;
    HourIn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if ({SyncMinIn, SyncHourIn} !== {2{i == 13}}) begin
        errors++;
        $display("FAIL simul off=%0d got=%b exp=%b",
                 i, {SyncMinIn, SyncHourIn}, {2{i == 13}});
      end
      if (i == 16) begin
        MinIn  = 1'b0;
        HourIn = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic e;
    align4();
    MinIn = 1'b1;
    for (int i = 1; i <= 46; i++) begin
      step();
      e = (i inside {13, 37, 45});
      checks++;
      if (SyncMinIn !== e) begin
        errors++;
        $display("FAIL prereset off=%0d got=%b exp=%b",
                 i, SyncMinIn, e);
      end
    end
    nReset = 1'b0;
    #1;
    checks++;
    if ({Tick, SyncMinIn, SyncHourIn} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got=%b exp=000",
               {Tick, SyncMinIn, SyncHourIn});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({Tick, SyncMinIn, SyncHourIn} !== 3'b000) begin
        errors++;
        $display("FAIL in_reset got=%b exp=000",
                 {Tick, SyncMinIn, SyncHourIn});
      end
    end
    nReset = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 48; i++) begin
      step();
      e = (i inside {13, 37, 45});
      checks++;
      if (SyncMinIn !== e) begin
        errors++;
        $display("FAIL postreset off=%0d got=%b exp=%b",
                 i, SyncMinIn, e);
      end
      checks++;
      if (Tick !== (i % 8 == 0)) begin
        errors++;
        $display("FAIL postreset_tick off=%0d got=%b exp=%b",
                 i, Tick, (i % 8 == 0));
      end
    end
    MinIn = 1'b0;
    for (int i = 0; i < 20; i++) step();
  endtask

  initial begin
    test_reset();
    test_tick_idle();
    test_single_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
